// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package cpu_mem_pkg;

   localparam int XLEN = 32;

   // Arbiter FSM states. BUSY_x holds the memory request for owner x.
   // RESP pulses the owner's ack.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      RESP    = 2'd3
   } arb_state_t;

   // Which pipeline stage owns the access currently in flight.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported unified memory shared between instruction fetch (IF) and
// data access (MEM). Data has priority over fetch. A streak counter forces
// an IF grant after MAX_DM_STREAK back-to-back data grants while IF waits.
//
// Handshakes:
// - Requester side: a requester raises req together with its address and
//   data, and holds them until its one-cycle ack pulse.
// - Memory side: the arbiter holds mem_req_o with a stable addr, we and
//   wdata until mem_ready_i is sampled high. mem_rdata_i is valid in that
//   same cycle.
// - mem_ready_i is ignored whenever no memory request is outstanding.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int MAX_DM_STREAK = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // instruction fetch port
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_ack_o,
   output logic [XLEN-1:0] if_rdata_o,
   // data access port
   input  logic            dm_req_i,
   input  logic            dm_we_i,
   input  logic [XLEN-1:0] dm_addr_i,
   input  logic [XLEN-1:0] dm_wdata_i,
   output logic            dm_ack_o,
   output logic [XLEN-1:0] dm_rdata_o,
   // memory port
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_ready_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   // pipeline freeze and FSM visibility
   output logic            stall_o,
   output arb_state_t      state_o
);

   localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

   arb_state_t            state_q, state_d;
   arb_owner_t            owner_q, owner_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic [XLEN-1:0]       addr_q, addr_d;
   logic                  we_q, we_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [XLEN-1:0]       if_rdata_q, if_rdata_d;
   logic [XLEN-1:0]       dm_rdata_q, dm_rdata_d;
   logic                  if_ack_q, if_ack_d;
   logic                  dm_ack_q, dm_ack_d;
   logic                  mem_req_q, mem_req_d;

   logic                  grant_dm;
   logic                  grant_if;

   // Data wins unless IF is waiting and data has already used its streak.
   assign grant_dm = dm_req_i & (~if_req_i | (streak_q < STREAK_MAX));
   assign grant_if = ~grant_dm & if_req_i;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: grant from IDLE, wait for memory in BUSY, one RESP cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_dm) begin
               state_d = BUSY_DM;
            end else if (grant_if) begin
               state_d = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_ready_i) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output/datapath next values: latch the granted request, track the
   // streak, capture read data and schedule the ack pulse.
   always_comb begin
      owner_d    = owner_q;
      streak_d   = streak_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      mem_req_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_dm) begin
               owner_d   = OWN_DM;
               addr_d    = dm_addr_i;
               we_d      = dm_we_i;
               wdata_d   = dm_wdata_i;
               mem_req_d = 1'b1;
               if (streak_q < STREAK_MAX) begin
                  streak_d = streak_q + STREAK_ONE;
               end
            end else if (grant_if) begin
               owner_d   = OWN_IF;
               addr_d    = if_addr_i;
               we_d      = 1'b0;
               wdata_d   = '0;
               mem_req_d = 1'b1;
               streak_d  = '0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            mem_req_d = ~mem_ready_i;
            if (mem_ready_i) begin
               if (owner_q == OWN_IF) begin
                  if_rdata_d = mem_rdata_i;
                  if_ack_d   = 1'b1;
               end else begin
                  // A store has no read data to return.
                  dm_rdata_d = we_q ? '0 : mem_rdata_i;
                  dm_ack_d   = 1'b1;
               end
            end
         end
         RESP: begin
            mem_req_d = 1'b0;
         end
         default: begin
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         owner_q    <= OWN_IF;
         streak_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         mem_req_q  <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         streak_q   <= streak_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         mem_req_q  <= mem_req_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_ack_o    = if_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_ack_o    = dm_ack_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign state_o     = state_q;

   // Freeze the pipeline while any stage has an unanswered request.
   assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and data-access (MEM) stage. It grants one access at a time with data-over-fetch priority and a bounded anti-starvation streak, and drives a variable-latency memory with a req/ready handshake. It also produces the pipeline-wide `stall_o` that freezes PC, IF_ID and the downstream pipeline registers while either stage waits.

## Interface
- `MAX_DM_STREAK`, default 4: number of consecutive data grants allowed while IF is pending before IF is forced a grant; must be ≥1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `if_req_i`  in  1  fetch request; held until `if_ack_o`.
- `if_addr_i`  in  32  fetch byte address.
- `if_ack_o`  out  1  one-cycle fetch completion pulse.
- `if_rdata_o`  out  32  fetched instruction; valid with `if_ack_o` and held afterwards.
- `dm_req_i`  in  1  data request; held until `dm_ack_o`.
- `dm_we_i`  in  1  1 = store, 0 = load.
- `dm_addr_i`  in  32  data byte address.
- `dm_wdata_i`  in  32  store data.
- `dm_ack_o`  out  1  one-cycle data completion pulse.
- `dm_rdata_o`  out  32  load data; valid with `dm_ack_o` and held afterwards.
- `mem_req_o`  out  1  memory request; held high until `mem_ready_i`.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  32  memory address.
- `mem_wdata_o`  out  32  memory write data.
- `mem_ready_i`  in  1  memory completion; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  memory read data.
- `stall_o`  out  1  pipeline freeze.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE, grant decision, in priority order:
  - If `dm_req_i` is high and (`if_req_i` is low or streak < `MAX_DM_STREAK`): latch the dm request (addr, we, wdata), go to BUSY_DM, and increment streak (saturating).
  - Otherwise, if `if_req_i` is high: latch the IF request, go to BUSY_IF, and clear streak.
  - Otherwise, stay in IDLE.
- BUSY_x:
  - `mem_req_o`=1; `mem_addr_o`, `mem_we_o` and `mem_wdata_o` come from the latched request.
  - On `mem_ready_i`: capture `mem_rdata_i` into the owner's rdata register and go to RESP.
  - For a store, `dm_rdata_o` is loaded with 0.
  - `mem_we_o` is always 0 for IF.
- RESP: pulse the owner's ack for one cycle, take no new grant, go to IDLE. The requester's still-high req in the ack cycle is never re-granted.
- Streak counter: width `$clog2(MAX_DM_STREAK+1)`. It is cleared on every IF grant. It is not cleared when IF is idle, but it only matters while `if_req_i`=1.
- `stall_o` = (`if_req_i` & ~`if_ack_o`) | (`dm_req_i` & ~`dm_ack_o`); combinational.
- Boundary conditions:
  - `mem_ready_i` in IDLE or RESP is ignored.
  - A requester dropping req during BUSY does not abort the access; the ack still pulses.
  - Latched address and data do not track input changes after the grant.
- Reset (`rst_i`=0, any time, including mid-access):
  - State goes to IDLE and streak to 0.
  - `mem_req_o`, `mem_we_o`, both acks and `stall_o` drive 0 (apart from stall's combinational input term).
  - `mem_addr_o`, `mem_wdata_o` and both rdata outputs drive 0.
  - The in-flight access is abandoned and no ack is issued.

## Timing
- Request sampled high in IDLE at edge N: `mem_req_o` is high from cycle N+1.
- `mem_ready_i` sampled at edge M: ack and rdata are visible in cycle M+1 (RESP).
- IDLE is re-entered at M+2.
- Minimum access latency is 3 cycles from request to ack, with zero-wait memory (ready in the first BUSY cycle).
- Back-to-back grants are separated by at least one RESP cycle and one IDLE cycle.
- All outputs except `stall_o` are registered.

## Structure
- Package `cpu_mem_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY_IF, BUSY_DM, RESP);
  - the `arb_owner_t` enum (OWN_IF, OWN_DM);
  - the `XLEN`=32 constant.
- Single module with no sub-modules; the streak counter is inline.

## Test plan
- IF-only read: `if_req_i`=1, `if_addr_i`=0x10 at cycle 0; memory returns ready with 0x00A00093 in cycle 2 → `mem_req_o` high in cycles 1–2, `if_ack_o` pulses in cycle 3 with `if_rdata_o`=0x00A00093, and `stall_o` is low from cycle 3.
- Simultaneous requests (if 0x20, dm load 0x100), zero-wait memory → the first `mem_addr_o` is 0x100 and `dm_ack_o` pulses first; the IF access to 0x20 starts after IDLE and `if_ack_o` follows.
- Starvation, `MAX_DM_STREAK`=4: `dm_req_i` and `if_req_i` held continuously → exactly 4 dm grants, then 1 IF grant, then dm grants resume.
- Store: `dm_we_i`=1, addr 0x20, wdata 0xDEADBEEF → `mem_we_o`=1 and `mem_wdata_o`=0xDEADBEEF during BUSY; `dm_ack_o` pulses with `dm_rdata_o`=0.
- Reset mid-access: `rst_i` low during BUSY_DM → `mem_req_o`=0 asynchronously; after release, a late `mem_ready_i` pulse produces no ack and the state remains IDLE.
- Ignored completion: `mem_ready_i`=1 in IDLE with no requests → no ack, no state change.
